// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Breaks a shift of 0..15 positions into shifter steps of at most 3 positions.
// The controller loads the shifter and then issues LSL/LSR/ASR steps. When the
// remaining distance reaches zero it pulses done for one cycle. During that
// cycle the shifter register holds the final result. Every output comes
// straight from a flop.
//
// Optional feature (compile-time macro): SHIFT_SEQ_ABORT_EN
//   When this macro is defined, the abort_i input is added. abort_i cancels a
//   request that is in LOAD or SHIFT.
//
// Ports
//   clk_i       in   1  clock, rising edge
//   reset_i     in   1  asynchronous active-high reset
//   start_i     in   1  request strobe, sampled only in IDLE
//   op_sel_i    in   2  00 LSL, 01 LSR, 10 ASR, 11 reserved (rejected)
//   amt_i       in   4  total shift distance, captured with start_i
//   abort_i     in   1  cancel request (SHIFT_SEQ_ABORT_EN only)
//   op_o        out  3  000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
//   shamt_o     out  2  per-step shift amount
//   busy_o      out  1  high in every state except IDLE
//   done_o      out  1  one-cycle completion pulse
//   err_o       out  1  one-cycle pulse on a rejected or aborted request
//   step_cnt_o  out  3  shift steps issued for the current request
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// LOAD   | shifter loads its operand (one cycle)
// SHIFT  | one shift step of min(remaining,3) issued per cycle
// DONE   | done pulse, shifter holds result (one cycle)
// -----------------------------------------------------------------------------
module shift_seq_ctrl (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] op_sel_i,
  input  logic [3:0] amt_i,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic       abort_i,
`endif
  output logic [2:0] op_o,
  output logic [1:0] shamt_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] step_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_LSL  = 3'd2;
  localparam logic [2:0] OP_LSR  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;

  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] opsel_q, opsel_d;
  logic [2:0] step_q, step_d;
  logic [2:0] op_q, op_d;
  logic [1:0] shamt_q, shamt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [1:0] step_amt;
  logic [2:0] shift_op;

  // The next step takes at most 3 positions of the remaining distance.
  assign step_amt = (rem_q > 4'd3) ? 2'd3 : rem_q[1:0];

  always_comb begin
    shift_op = OP_NOP;
    case (opsel_q)
      2'b00:   shift_op = OP_LSL;
      2'b01:   shift_op = OP_LSR;
      2'b10:   shift_op = OP_ASR;
      default: shift_op = OP_NOP;
    endcase
  end

  // Each output is computed for the state being entered, so the registered
  // output always matches the state register.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    opsel_d = opsel_q;
    step_d  = step_q;
    op_d    = OP_NOP;
    shamt_d = 2'd0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          if (op_sel_i == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            opsel_d = op_sel_i;
            rem_d   = amt_i;
            step_d  = 3'd0;
            op_d    = OP_LOAD;
            busy_d  = 1'b1;
          end
        end
      end
      // LOAD and SHIFT use the same decision: if any distance remains, issue
      // another step, otherwise finish.
      S_LOAD, S_SHIFT: begin
        if (rem_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
          op_d    = shift_op;
          shamt_d = step_amt;
          rem_d   = rem_q - {2'b00, step_amt};
          step_d  = step_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort takes precedence over the normal sequence. step_cnt_o keeps the
    // number of steps that were already issued.
    if (abort_i && (state_q == S_LOAD || state_q == S_SHIFT)) begin
      state_d = S_IDLE;
      rem_d   = rem_q;
      step_d  = step_q;
      op_d    = OP_NOP;
      shamt_d = 2'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      opsel_q <= 2'd0;
      step_q  <= 3'd0;
      op_q    <= OP_NOP;
      shamt_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      opsel_q <= opsel_d;
      step_q  <= step_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign op_o       = op_q;
  assign shamt_o    = shamt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign step_cnt_o = step_q;

endmodule
